// File: rtl/pl_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, EX redirects, data-memory wait and timeout error.
// Define PL_PERF_CNT_EN to build the stall/flush performance counters (tied to zero otherwise).
module pl_hazard_ctrl #(
    parameter logic [7:0] MEM_TIMEOUT = 8'd200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        B_type_mispredict_ex,
    input  logic        jalr_ex,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    output logic        PL_stall,
    output logic        PL_flush,
    output logic        id_ex_flush,
    output logic        mem_stall_all,
    output logic        redirect_valid,
    output logic        mem_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    state_e     r_state;
    logic [7:0] r_wait_cnt;
    logic       w_load_use;
    logic       w_redirect;
    logic       w_mem_miss;

    assign w_load_use = ex_memread && (ex_rd != 5'd0) &&
                        ((id_rs1_used && (id_rs1 == ex_rd)) ||
                         (id_rs2_used && (id_rs2 == ex_rd)));
    assign w_redirect = B_type_mispredict_ex | jalr_ex;
    assign w_mem_miss = dmem_req & ~dmem_ack;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        PL_stall       = 1'b0;
        PL_flush       = 1'b0;
        id_ex_flush    = 1'b0;
        mem_stall_all  = 1'b0;
        redirect_valid = 1'b0;
        mem_err        = 1'b0;
        if (rst_n) begin
            case (r_state)
                RUN: begin
                    if (w_mem_miss) begin
                        mem_stall_all = 1'b1;
                        PL_stall      = 1'b1;
                    end else if (w_redirect) begin
                        PL_flush       = 1'b1;
                        id_ex_flush    = 1'b1;
                        redirect_valid = 1'b1;
                    end else if (w_load_use) begin
                        PL_stall    = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    mem_stall_all = 1'b1;
                    PL_stall      = 1'b1;
                end
                ERR: begin
                    mem_stall_all = 1'b1;
                    PL_stall      = 1'b1;
                    mem_err       = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= 8'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_miss) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ack) begin
                        r_state    <= RUN;
                        r_wait_cnt <= 8'd0;
                    end else begin
                        if (r_wait_cnt == MEM_TIMEOUT) r_state <= ERR;
                        if (r_wait_cnt != 8'hFF) r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ERR:     r_state <= ERR;
                default: r_state <= RUN;
            endcase
        end
    end

`ifdef PL_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (PL_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (PL_flush) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Self-checking bench for pl_hazard_ctrl: directed scenarios plus random traffic against a rule-level model.
// Two instances share all inputs: the default MEM_TIMEOUT and a short MEM_TIMEOUT of 4.
module tb_pl_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_rs1_used, id_rs2_used, ex_memread;
    logic        B_type_mispredict_ex, jalr_ex, dmem_req, dmem_ack;

    logic        pl_stall_o[2], pl_flush_o[2], id_ex_flush_o[2];
    logic        mem_stall_all_o[2], redirect_valid_o[2], mem_err_o[2];
    logic [31:0] stall_cnt_o[2], flush_cnt_o[2];

    int n_asserts = 0;
    int n_fail    = 0;

    // Model: per instance, whether a memory wait is pending, how long it has waited, and whether it timed out.
    int          tmo[2] = '{200, 4};
    bit          m_waiting[2], m_failed[2];
    int          m_waited[2];
    logic [31:0] m_scnt[2], m_fcnt[2];

    always #5 clk = ~clk;

    pl_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_memread(ex_memread), .ex_rd(ex_rd),
        .B_type_mispredict_ex(B_type_mispredict_ex), .jalr_ex(jalr_ex),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .PL_stall(pl_stall_o[0]), .PL_flush(pl_flush_o[0]), .id_ex_flush(id_ex_flush_o[0]),
        .mem_stall_all(mem_stall_all_o[0]), .redirect_valid(redirect_valid_o[0]),
        .mem_err(mem_err_o[0]), .stall_cnt(stall_cnt_o[0]), .flush_cnt(flush_cnt_o[0])
    );

    pl_hazard_ctrl #(.MEM_TIMEOUT(8'd4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_memread(ex_memread), .ex_rd(ex_rd),
        .B_type_mispredict_ex(B_type_mispredict_ex), .jalr_ex(jalr_ex),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .PL_stall(pl_stall_o[1]), .PL_flush(pl_flush_o[1]), .id_ex_flush(id_ex_flush_o[1]),
        .mem_stall_all(mem_stall_all_o[1]), .redirect_valid(redirect_valid_o[1]),
        .mem_err(mem_err_o[1]), .stall_cnt(stall_cnt_o[1]), .flush_cnt(flush_cnt_o[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_memread = 1'b0; ex_rd = 5'd0;
        B_type_mispredict_ex = 1'b0; jalr_ex = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
    endtask

    // Constant expectations on the default instance for the directed scenarios.
    task automatic expect_ctrl(input string tag, input bit stall, input bit flush, input bit idex,
                               input bit all, input bit redir);
        #1;
        check({tag, " PL_stall"}, 32'(pl_stall_o[0]), 32'(stall));
        check({tag, " PL_flush"}, 32'(pl_flush_o[0]), 32'(flush));
        check({tag, " id_ex_flush"}, 32'(id_ex_flush_o[0]), 32'(idex));
        check({tag, " mem_stall_all"}, 32'(mem_stall_all_o[0]), 32'(all));
        check({tag, " redirect_valid"}, 32'(redirect_valid_o[0]), 32'(redir));
    endtask

    // Compare both instances with the model for the current inputs, advance the model, move to next negedge.
    task automatic cycle();
        bit lu, redir, miss;
        bit e_stall, e_flush, e_idex, e_all, e_redir, e_err;
        logic [31:0] e_scnt, e_fcnt;
        #1;
        lu = ex_memread && (ex_rd != 0) &&
             ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        redir = B_type_mispredict_ex || jalr_ex;
        miss  = dmem_req && !dmem_ack;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_waiting[k] = 0; m_failed[k] = 0; m_waited[k] = 0;
                m_scnt[k] = 0; m_fcnt[k] = 0;
            end
            {e_stall, e_flush, e_idex, e_all, e_redir, e_err} = '0;
            if (rst_n) begin
                if (m_failed[k]) {e_all, e_stall, e_err} = 3'b111;
                else if (m_waiting[k] || miss) {e_all, e_stall} = 2'b11;
                else if (redir) {e_flush, e_idex, e_redir} = 3'b111;
                else if (lu) {e_stall, e_idex} = 2'b11;
            end
`ifdef PL_PERF_CNT_EN
            e_scnt = m_scnt[k]; e_fcnt = m_fcnt[k];
`else
            e_scnt = 32'd0; e_fcnt = 32'd0;
`endif
            check($sformatf("i%0d PL_stall", k), 32'(pl_stall_o[k]), 32'(e_stall));
            check($sformatf("i%0d PL_flush", k), 32'(pl_flush_o[k]), 32'(e_flush));
            check($sformatf("i%0d id_ex_flush", k), 32'(id_ex_flush_o[k]), 32'(e_idex));
            check($sformatf("i%0d mem_stall_all", k), 32'(mem_stall_all_o[k]), 32'(e_all));
            check($sformatf("i%0d redirect_valid", k), 32'(redirect_valid_o[k]), 32'(e_redir));
            check($sformatf("i%0d mem_err", k), 32'(mem_err_o[k]), 32'(e_err));
            check($sformatf("i%0d stall_cnt", k), stall_cnt_o[k], e_scnt);
            check($sformatf("i%0d flush_cnt", k), flush_cnt_o[k], e_fcnt);
            if (rst_n) begin
                m_scnt[k] += 32'(e_stall);
                m_fcnt[k] += 32'(e_flush);
                if (m_failed[k]) begin
                end else if (m_waiting[k]) begin
                    if (dmem_ack) begin
                        m_waiting[k] = 0; m_waited[k] = 0;
                    end else if (m_waited[k] == tmo[k]) begin
                        m_failed[k] = 1;
                    end else if (m_waited[k] < 255) begin
                        m_waited[k]++;
                    end
                end else if (miss) begin
                    m_waiting[k] = 1; m_waited[k] = 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_s, exp_f;
        clr();
        rst_n = 1'b0;
        @(negedge clk);

        // Reset with hostile inputs: all outputs must be forced low.
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
        dmem_req = 1'b1; jalr_ex = 1'b1;
        expect_ctrl("in_reset", 0, 0, 0, 0, 0);
        cycle();
        rst_n = 1'b1;
        clr();
        cycle();

        // Load-use: one bubble, then the load has left EX.
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
        expect_ctrl("load_use", 1, 0, 1, 0, 0);
        cycle();
        ex_memread = 1'b0;
        expect_ctrl("after_load", 0, 0, 0, 0, 0);
        cycle();
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
        expect_ctrl("rd_zero", 0, 0, 0, 0, 0);
        cycle();
        ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b0;
        expect_ctrl("rs1_unused", 0, 0, 0, 0, 0);
        cycle();
        id_rs2 = 5'd5; id_rs2_used = 1'b1;
        expect_ctrl("rs2_load_use", 1, 0, 1, 0, 0);
        cycle();
        B_type_mispredict_ex = 1'b1;
        expect_ctrl("redirect_over_lu", 0, 1, 1, 0, 1);
        cycle();

        // Memory wait with a JALR frozen in EX: 4 stall cycles, then the redirect.
        clr();
        jalr_ex = 1'b1; dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dmem_ack = (i == 3);
            expect_ctrl($sformatf("mem_wait%0d", i), 1, 0, 0, 1, 0);
            cycle();
        end
        dmem_req = 1'b0; dmem_ack = 1'b0;
        expect_ctrl("post_wait_redirect", 0, 1, 1, 0, 1);
        cycle();
        clr();
        dmem_req = 1'b1; dmem_ack = 1'b1;
        expect_ctrl("req_ack_same_cycle", 0, 0, 0, 0, 0);
        cycle();
        clr();
        cycle();

        // Performance counters: two load-use stalls and one redirect after a fresh reset.
        reset_pulse();
        clr();
        for (int i = 0; i < 2; i++) begin
            ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b1;
            cycle();
            clr();
            cycle();
        end
        jalr_ex = 1'b1;
        cycle();
        clr();
`ifdef PL_PERF_CNT_EN
        exp_s = 32'd2; exp_f = 32'd1;
`else
        exp_s = 32'd0; exp_f = 32'd0;
`endif
        #1;
        check("perf stall_cnt", stall_cnt_o[0], exp_s);
        check("perf flush_cnt", flush_cnt_o[0], exp_f);
        cycle();

        // Timeout: short instance errors after 4 waits; default instance after MEM_TIMEOUT waits.
        dmem_req = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        #1;
        check("tmo4 mem_err", 32'(mem_err_o[1]), 32'd1);
        check("tmo200 no err yet", 32'(mem_err_o[0]), 32'd0);
        for (int i = 0; i < 200; i++) cycle();
        #1;
        check("tmo200 mem_err", 32'(mem_err_o[0]), 32'd1);
        dmem_ack = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        #1;
        check("err sticky", 32'(mem_err_o[0]), 32'd1);
        reset_pulse();
        clr();
        #1;
        check("err cleared", 32'(mem_err_o[0]), 32'd0);
        check("err cleared short", 32'(mem_err_o[1]), 32'd0);
        cycle();
        ex_memread = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; id_rs2_used = 1'b1;
        expect_ctrl("run_after_reset", 1, 0, 1, 0, 0);
        cycle();

        // Random traffic with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            rst_n                = ($urandom_range(0, 99) != 0);
            id_rs1               = 5'($urandom_range(0, 3));
            id_rs2               = 5'($urandom_range(0, 3));
            ex_rd                = 5'($urandom_range(0, 3));
            id_rs1_used          = 1'($urandom_range(0, 1));
            id_rs2_used          = 1'($urandom_range(0, 1));
            ex_memread           = 1'($urandom_range(0, 1));
            B_type_mispredict_ex = ($urandom_range(0, 9) == 0);
            jalr_ex              = ($urandom_range(0, 9) == 0);
            dmem_req             = ($urandom_range(0, 4) == 0);
            dmem_ack             = ($urandom_range(0, 4) < 2);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
